// File: rtl/tt_uio_pkg.sv
// tt_uio_pkg: transmitter FSM states and uio pin assignments (ack in, strobe out, output enables)
package tt_uio_pkg;
  typedef enum logic [2:0] {IDLE, HI_SETUP, HI_REQ, HI_REL, LO_SETUP, LO_REQ, LO_REL} tx_state_e;
  localparam int UIO_ACK_BIT = 5;
  localparam int UIO_STB_BIT = 4;
  localparam logic [7:0] UIO_TX_OE = 8'h1F;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO; push/wdata in, pop/rdata (show-ahead) out, full/empty flags, sync active-high reset
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rptr[AW-1:0]];
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  always_ff @(posedge clk)
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  always_ff @(posedge clk)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
    end
endmodule

// File: rtl/tt_uio_nibble_tx.sv
// tt_uio_nibble_tx: buffers bytes (s_data/s_valid/s_ready) and sends them as two nibbles on uio_out[3:0] with strobe uio_out[4] / ack uio_in[5]; busy, sticky err
module tt_uio_nibble_tx
  import tt_uio_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic       busy,
  output logic       err
);
  localparam logic [7:0] TMO = 8'(ACK_TIMEOUT);
  tx_state_e state, nxt;
  logic ack_m, ack_s, full, empty, push, pop, stb, is_req, done, unused_uio;
  logic [7:0] tx_byte, rdata, timer;
  logic [3:0] nib;
  assign unused_uio = &{1'b0, uio_in[7:6], uio_in[4:0]};
  assign s_ready = !full && !reset && ena;
  assign push = s_valid && s_ready;
  assign pop = ena && state == IDLE && !empty && !ack_s;
  assign busy = state != IDLE || !empty;
  assign is_req = state == HI_REQ || state == LO_REQ;
  assign done = is_req ? ack_s : !ack_s;
  assign nxt = state == LO_REL ? IDLE : tx_state_e'(state + 3'd1);
  always_comb begin
    uio_out = '0;
    uio_out[UIO_STB_BIT] = stb;
    uio_out[3:0] = nib;
  end
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .wdata(s_data),
    .pop(pop), .rdata(rdata), .full(full), .empty(empty)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      tx_byte <= '0;
      nib <= '0;
      stb <= 1'b0;
      timer <= '0;
      err <= 1'b0;
      uio_oe <= '0;
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      uio_oe <= UIO_TX_OE;
      ack_m <= uio_in[UIO_ACK_BIT];
      ack_s <= ack_m;
      if (ena)
        case (state)
          IDLE: if (pop) begin
            tx_byte <= rdata;
            state <= HI_SETUP;
          end
          HI_SETUP, LO_SETUP: begin
            nib <= state == HI_SETUP ? tx_byte[7:4] : tx_byte[3:0];
            timer <= '0;
            state <= nxt;
          end
          default: begin
            stb <= is_req;
            if (done) begin
              timer <= '0;
              state <= nxt;
            end else if (timer == TMO) begin
              err <= 1'b1;
              stb <= 1'b0;
              nib <= '0;
              state <= IDLE;
            end else timer <= timer + 8'd1;
          end
        endcase
    end
endmodule
